// File: rtl/fb_pkg.sv
// Shared constants, AXI encodings and types for the frame-buffer scan-out engine.
package fb_pkg;

    localparam int unsigned FB_H_RES      = 400;
    localparam int unsigned FB_V_RES      = 300;
    localparam int unsigned FB_WORDS      = FB_H_RES * FB_V_RES;
    localparam int unsigned FB_BURST_LEN  = 16;
    localparam int unsigned FB_FIFO_DEPTH = 64;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } rd_state_e;

    // AXI read-address payload as presented on the AR channel
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_ar_t;

endpackage

// File: rtl/fb_scanout_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible on pop_data
// whenever count is non-zero.
module fb_scanout_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define contents
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scan-out: AXI4 INCR-burst read master feeding a credit-managed
// pixel FIFO, emitting a raster-ordered pixel stream with SOF/EOL markers.
module fb_scanout
    import fb_pkg::*;
#(
    parameter logic [31:0] FB_BASE    = 32'h0000_0000,
    parameter int unsigned H_RES      = FB_H_RES,
    parameter int unsigned V_RES      = FB_V_RES,
    parameter int unsigned BURST_LEN  = FB_BURST_LEN,
    parameter int unsigned FIFO_DEPTH = FB_FIFO_DEPTH,
    parameter logic [3:0]  AXI_ID     = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        ar_valid,
    input  logic        ar_ready,
    output logic [31:0] ar_addr,
    output logic [3:0]  ar_id,
    output logic [7:0]  ar_len,
    output logic [2:0]  ar_size,
    output logic [1:0]  ar_burst,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [31:0] r_data,
    input  logic [3:0]  r_id,
    input  logic [1:0]  r_resp,
    input  logic        r_last,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [31:0] pix_data,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        frame_done,
    output logic        rd_err
);

    localparam int unsigned WORDS = H_RES * V_RES;
    localparam int unsigned WIW   = $clog2(WORDS) + 1;
    localparam int unsigned BW    = $clog2(BURST_LEN);
    localparam int unsigned RW    = $clog2(BURST_LEN + 1);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned XW    = $clog2(H_RES);
    localparam int unsigned YW    = $clog2(V_RES);

    if ((WORDS % BURST_LEN) != 0) begin : g_bad_geometry
        $error("fb_scanout: H_RES*V_RES must be a multiple of BURST_LEN");
    end
    if (FIFO_DEPTH < 2 * BURST_LEN || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fb_scanout: FIFO_DEPTH must be a power of 2 and >= 2*BURST_LEN");
    end

    rd_state_e        state;
    rd_state_e        state_nxt;
    logic [WIW-1:0]   word_idx;
    logic [BW-1:0]    beat_cnt;
    logic [RW-1:0]    reserved;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [CW-1:0]    fifo_count;
    logic [31:0]      fifo_head;
    logic [CW:0]      free_credits;
    logic             ar_valid_c;
    logic             ar_hs;
    logic             push;
    logic             pop;
    logic             final_beat;
    logic             last_beat;
    logic [WIW-1:0]   word_next;
    logic             wrap;
    logic             x_last;
    logic             y_last;
    axi_ar_t          ar_c;
    logic             unused_ok;

    assign unused_ok = ^r_id;

    // Credits: FIFO slots neither occupied nor promised to the burst in flight
    assign free_credits = (CW+1)'(FIFO_DEPTH) - (CW+1)'(fifo_count) - (CW+1)'(reserved);
    assign ar_valid_c   = (state == ADDR) && (free_credits >= (CW+1)'(BURST_LEN));
    assign ar_hs        = ar_valid_c && ar_ready;
    assign push         = (state == DATA) && r_valid;
    assign final_beat   = (beat_cnt == BW'(BURST_LEN - 1));
    assign last_beat    = push && (final_beat || r_last);
    assign word_next    = word_idx + WIW'(BURST_LEN);
    assign wrap         = (word_next == WIW'(WORDS));
    assign pop          = pix_valid && pix_ready;
    assign x_last       = (x == XW'(H_RES - 1));
    assign y_last       = (y == YW'(V_RES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read FSM: once a frame has started it always finishes; enable is only
    // consulted at frame boundaries
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable)   state_nxt = ADDR;
            ADDR: if (ar_hs)    state_nxt = DATA;
            DATA: if (last_beat) state_nxt = (wrap && !enable) ? IDLE : ADDR;
            default:            state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_idx <= '0;
            beat_cnt <= '0;
            reserved <= '0;
            rd_err   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                word_idx <= '0;
            end else if (last_beat) begin
                word_idx <= wrap ? '0 : word_next;
            end
            if (push) beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
            // An early r_last releases whatever reservation is left
            if (ar_hs) begin
                reserved <= RW'(BURST_LEN);
            end else if (last_beat) begin
                reserved <= '0;
            end else if (push) begin
                reserved <= reserved - RW'(1);
            end
            if (push && ((r_resp != AXI_RESP_OKAY) || (r_last != final_beat))) rd_err <= 1'b1;
        end
    end

    fb_scanout_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (r_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (fifo_count)
    );

    // Raster position of the pixel at the FIFO head
    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop && x_last && y_last;
            if (pop) begin
                x <= x_last ? '0 : x + XW'(1);
                if (x_last) y <= y_last ? '0 : y + YW'(1);
            end
        end
    end

    always_comb begin
        ar_c       = '0;
        ar_c.id    = AXI_ID;
        ar_c.len   = 8'(BURST_LEN - 1);
        ar_c.size  = AXI_SIZE_4B;
        ar_c.burst = AXI_BURST_INCR;
        if (ar_valid_c) ar_c.addr = FB_BASE + (32'(word_idx) << 2);
    end

    assign ar_valid  = ar_valid_c;
    assign ar_addr   = ar_c.addr;
    assign ar_id     = ar_c.id;
    assign ar_len    = ar_c.len;
    assign ar_size   = ar_c.size;
    assign ar_burst  = ar_c.burst;
    assign r_ready   = (state == DATA);
    assign pix_valid = (fifo_count != '0);
    assign pix_data  = pix_valid ? fifo_head : 32'h0;
    assign pix_sof   = pix_valid && (x == '0) && (y == '0);
    assign pix_eol   = pix_valid && x_last;

endmodule
